fetch_unit: RTL and testbench



---
 rtl/fetch_unit_pkg.sv | 12 +
 rtl/fetch_unit_if.sv | 22 ++
 rtl/fetch_unit_fifo.sv | 45 ++++
 rtl/fetch_unit.sv | 60 ++++++
 tb/tb_fetch_unit.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared constants, the buffered entry type and address helpers for the fetch stage.
package fetch_unit_pkg;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;
  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction
endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: imem request/response, redirect and decoder handshake bundle.
interface fetch_unit_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        ir_valid;
  logic [31:0] ir;
  logic [31:0] ir_pc;
  logic        ir_ready;
  modport master (
    output imem_req_valid, imem_req_addr, ir_valid, ir, ir_pc,
    input  imem_req_ready, imem_resp_valid, imem_resp_data, redirect_valid, redirect_pc, ir_ready
  );
  modport slave (
    input  imem_req_valid, imem_req_addr, ir_valid, ir, ir_pc,
    output imem_req_ready, imem_resp_valid, imem_resp_data, redirect_valid, redirect_pc, ir_ready
  );
endinterface

// File: rtl/fetch_unit_fifo.sv
// fetch_fifo: synchronous circular buffer; flush outranks push and pop.
module fetch_fifo #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [DATA_W-1:0]          din,
  output logic [DATA_W-1:0]          head,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic              full, do_push, do_pop;
  function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
    return p == AW'(DEPTH-1) ? '0 : p + 1'b1;
  endfunction
  assign empty   = count == '0;
  assign full    = count == CW'(DEPTH);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= do_push ? inc(wr_ptr) : wr_ptr;
      rd_ptr <= do_pop ? inc(rd_ptr) : rd_ptr;
      count  <= count + CW'(do_push) - CW'(do_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (!rst && !flush && do_push) mem[wr_ptr] <= din;
  end
  // The credit scheme upstream must make this unreachable.
  assert property (@(posedge clk) disable iff (rst) !(push && !flush && full));
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC generation, credit-limited imem requests, wrong-path response dropping,
// and buffered {ir, ir_pc} delivery to decode.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int          BUF_DEPTH = 2
) (
  input logic         clk,
  input logic         rst,
  fetch_unit_if.master bus
);
  localparam int CW = $clog2(BUF_DEPTH+1);
  logic [31:0]   fetch_pc, resp_pc, last_pc, target;
  logic [CW-1:0] outstanding, drop_cnt, fifo_count, drop_redirect;
  logic [CW:0]   inflight;
  logic          accept, push, pop, fifo_empty;
  fetch_entry_t  head, din;
  assign target   = word_align(bus.redirect_pc);
  assign inflight = {1'b0, outstanding} + {1'b0, fifo_count};
  assign bus.imem_req_valid = !rst && !bus.redirect_valid && inflight < (CW+1)'(BUF_DEPTH);
  assign bus.imem_req_addr  = word_align(fetch_pc);
  assign accept = bus.imem_req_valid && bus.imem_req_ready;
  assign push   = bus.imem_resp_valid && drop_cnt == '0 && !bus.redirect_valid;
  assign pop    = bus.ir_valid && bus.ir_ready && !bus.redirect_valid;
  assign din    = '{pc: resp_pc, instr: bus.imem_resp_data};
  assign bus.ir_valid = !fifo_empty;
  assign bus.ir       = fifo_empty ? NOP_INSTR : head.instr;
  assign bus.ir_pc    = fifo_empty ? last_pc : head.pc;
  // Everything still in flight is wrong-path after a redirect; outstanding already
  // includes earlier drops, so it alone sets the new discard count.
  assign drop_redirect = outstanding == '0 ? '0 : outstanding - CW'(bus.imem_resp_valid);
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      last_pc     <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= outstanding + CW'(accept) - CW'(bus.imem_resp_valid);
      fetch_pc    <= bus.redirect_valid ? target : accept ? fetch_pc + 32'd4 : fetch_pc;
      resp_pc     <= bus.redirect_valid ? target : push ? resp_pc + 32'd4 : resp_pc;
      last_pc     <= pop ? head.pc : last_pc;
      drop_cnt    <= bus.redirect_valid ? drop_redirect :
                     (bus.imem_resp_valid && drop_cnt != '0) ? drop_cnt - 1'b1 : drop_cnt;
    end
  end
  fetch_fifo #(.DATA_W($bits(fetch_entry_t)), .DEPTH(BUF_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (bus.redirect_valid),
    .din   (din),
    .head  (head),
    .count (fifo_count),
    .empty (fifo_empty)
  );
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed vector table plus hand-written redirect/stall/reset sequences.
module tb_fetch_unit;
  import fetch_unit_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  fetch_unit_if fi ();
  fetch_unit #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(2)) dut (.clk(clk), .rst(rst), .bus(fi));
  always #5 clk = ~clk;

  typedef struct { int due; logic [31:0] addr; } pend_t;
  typedef struct {
    logic rr; logic ird; logic rv; logic [31:0] addr; logic iv; logic [31:0] pc;
  } vec_t;
  pend_t pend[$];
  vec_t vt[13];
  int nvec = 0, nerr = 0, cyc = 0, lat = 1, npop = 0;
  logic [31:0] exp_req = 0, exp_pop = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    logic acc, pop, rd, was_rst;
    logic [31:0] a, rp;
    #1;
    acc = !rst && fi.imem_req_valid && fi.imem_req_ready;
    a   = fi.imem_req_addr;
    pop = !rst && !fi.redirect_valid && fi.ir_valid && fi.ir_ready;
    rd  = !rst && fi.redirect_valid;
    rp  = fi.redirect_pc;
    was_rst = rst;
    if (acc) begin
      chk("req_addr", a, exp_req);
      exp_req += 32'd4;
      pend.push_back('{cyc + lat, a});
    end
    if (pop) begin
      chk("pop_pc", fi.ir_pc, exp_pop);
      chk("pop_ir", fi.ir, ~exp_pop);
      exp_pop += 32'd4;
      npop++;
    end
    if (rd) begin
      exp_req = {rp[31:2], 2'b00};
      exp_pop = {rp[31:2], 2'b00};
    end
    if (was_rst) begin
      exp_req = 0;
      exp_pop = 0;
      pend.delete();
    end
    @(posedge clk);
    #1;
    cyc++;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      fi.imem_resp_valid = 1'b1;
      fi.imem_resp_data  = ~pend[0].addr;
      void'(pend.pop_front());
    end else begin
      fi.imem_resp_valid = 1'b0;
      fi.imem_resp_data  = 32'h0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    fi.redirect_valid = 1'b0;
    step();
    #1;
    chk("rst_req_valid", {31'b0, fi.imem_req_valid}, 0);
    chk("rst_ir_valid", {31'b0, fi.ir_valid}, 0);
    rst = 1'b0;
  endtask

  task automatic wait_acc(input string nm, input logic [31:0] exp);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      #1;
      if (fi.imem_req_valid && fi.imem_req_ready) ok = 1'b1;
      else step();
    end
    chk({nm, "_seen"}, {31'b0, ok}, 1);
    if (ok) chk(nm, fi.imem_req_addr, exp);
  endtask

  task automatic wait_iv(input string nm, input logic [31:0] exp_pc);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      #1;
      if (fi.ir_valid) ok = 1'b1;
      else step();
    end
    chk({nm, "_seen"}, {31'b0, ok}, 1);
    if (ok) begin
      chk({nm, "_pc"}, fi.ir_pc, exp_pc);
      chk({nm, "_ir"}, fi.ir, ~exp_pc);
    end
  endtask

  initial begin
    int n0;
    fi.imem_req_ready = 1'b1; fi.imem_resp_valid = 1'b0; fi.imem_resp_data = 32'h0;
    fi.redirect_valid = 1'b0; fi.redirect_pc = 32'h0; fi.ir_ready = 1'b1;
    vt[0]  = '{1, 1, 1, 32'h00, 0, 32'h00};
    vt[1]  = '{1, 1, 1, 32'h04, 0, 32'h00};
    vt[2]  = '{1, 1, 0, 32'h00, 1, 32'h00};
    vt[3]  = '{1, 1, 1, 32'h08, 1, 32'h04};
    vt[4]  = '{1, 1, 1, 32'h0C, 0, 32'h04};
    vt[5]  = '{1, 1, 0, 32'h00, 1, 32'h08};
    vt[6]  = '{1, 1, 1, 32'h10, 1, 32'h0C};
    vt[7]  = '{1, 1, 1, 32'h14, 0, 32'h0C};
    vt[8]  = '{1, 1, 0, 32'h00, 1, 32'h10};
    vt[9]  = '{0, 1, 1, 32'h18, 1, 32'h14};
    vt[10] = '{1, 1, 1, 32'h18, 0, 32'h14};
    vt[11] = '{1, 1, 1, 32'h1C, 0, 32'h14};
    vt[12] = '{1, 1, 0, 32'h00, 1, 32'h18};
    // streaming at latency 1
    do_reset();
    lat = 1;
    for (int i = 0; i < 13; i++) begin
      fi.imem_req_ready = vt[i].rr;
      fi.ir_ready = vt[i].ird;
      #1;
      chk($sformatf("v%0d_req_valid", i), {31'b0, fi.imem_req_valid}, {31'b0, vt[i].rv});
      if (vt[i].rv) chk($sformatf("v%0d_req_addr", i), fi.imem_req_addr, vt[i].addr);
      chk($sformatf("v%0d_ir_valid", i), {31'b0, fi.ir_valid}, {31'b0, vt[i].iv});
      chk($sformatf("v%0d_ir_pc", i), fi.ir_pc, vt[i].pc);
      chk($sformatf("v%0d_ir", i), fi.ir, vt[i].iv ? ~vt[i].pc : NOP_INSTR);
      step();
    end
    fi.imem_req_ready = 1'b1;
    // decoder stall: credit cap, held output, clean resume
    do_reset();
    fi.ir_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (c >= 2) begin
        chk("stall_req_valid", {31'b0, fi.imem_req_valid}, 0);
        chk("stall_ir_valid", {31'b0, fi.ir_valid}, 1);
        chk("stall_ir_pc", fi.ir_pc, 32'h0);
        chk("stall_ir", fi.ir, ~32'h0);
      end
      step();
    end
    fi.ir_ready = 1'b1;
    n0 = npop;
    repeat (12) step();
    chk("release_pops", npop - n0, 8);
    // latency 3, redirect with two requests in flight
    do_reset();
    lat = 3;
    step();
    step();
    fi.redirect_valid = 1'b1; fi.redirect_pc = 32'h100;
    #1;
    chk("rd_cycle_req_valid", {31'b0, fi.imem_req_valid}, 0);
    step();
    fi.redirect_valid = 1'b0;
    #1;
    chk("drop_req_valid", {31'b0, fi.imem_req_valid}, 0);
    step();
    wait_iv("rd_lat3", 32'h100);
    repeat (6) step();
    // redirect coinciding with a response and a pop
    do_reset();
    lat = 1;
    step();
    step();
    fi.redirect_valid = 1'b1; fi.redirect_pc = 32'h100;
    #1;
    chk("coinc_ir_valid_before", {31'b0, fi.ir_valid}, 1);
    chk("coinc_req_valid", {31'b0, fi.imem_req_valid}, 0);
    step();
    fi.redirect_valid = 1'b0;
    #1;
    chk("coinc_ir_valid_after", {31'b0, fi.ir_valid}, 0);
    chk("coinc_ir_nop", fi.ir, NOP_INSTR);
    chk("coinc_ir_pc", fi.ir_pc, 32'h0);
    chk("coinc_req_valid_next", {31'b0, fi.imem_req_valid}, 1);
    chk("coinc_req_addr_next", fi.imem_req_addr, 32'h100);
    step();
    wait_iv("coinc", 32'h100);
    repeat (4) step();
    // unaligned target and address wrap
    do_reset();
    fi.redirect_valid = 1'b1; fi.redirect_pc = 32'h0000_0106;
    step();
    fi.redirect_valid = 1'b0;
    wait_acc("align_addr", 32'h104);
    repeat (6) step();
    fi.redirect_valid = 1'b1; fi.redirect_pc = 32'hFFFF_FFFC;
    step();
    fi.redirect_valid = 1'b0;
    wait_acc("wrap_first", 32'hFFFF_FFFC);
    step();
    wait_acc("wrap_next", 32'h0);
    n0 = npop;
    repeat (8) step();
    chk("wrap_pops", {31'b0, npop - n0 >= 4}, 1);
    // reset with a full buffer
    do_reset();
    fi.ir_ready = 1'b0;
    repeat (6) step();
    #1;
    chk("full_ir_valid", {31'b0, fi.ir_valid}, 1);
    chk("full_req_valid", {31'b0, fi.imem_req_valid}, 0);
    do_reset();
    #1;
    chk("mid_rst_ir_valid", {31'b0, fi.ir_valid}, 0);
    chk("mid_rst_ir", fi.ir, NOP_INSTR);
    chk("mid_rst_ir_pc", fi.ir_pc, 32'h0);
    chk("mid_rst_req_valid", {31'b0, fi.imem_req_valid}, 1);
    chk("mid_rst_req_addr", fi.imem_req_addr, 32'h0);
    fi.ir_ready = 1'b1;
    repeat (6) step();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
